nn_dense_layer: RTL and testbench
=================================

# nn_dense_layer

Fully connected neural-network layer that consumes the NN_ARRAY_WIDTH-element feature vector produced by the upstream feature FIFO. It computes NUM_NEURONS outputs by serial multiply-accumulate over a synchronous weight memory, then applies bias, rescaling, saturation and optional ReLU. Results are streamed out one neuron at a time. It sits directly downstream of the feature FIFO and feeds the next network layer or the classifier.

## Interface
- NN_DATA_WIDTH, 16, signed fixed-point width of inputs, weights, biases and outputs
- NN_ARRAY_WIDTH, 26, number of input features (A)
- NUM_NEURONS, 8, number of output neurons (N)
- FRAC_BITS, 8, fractional bits of the Q format
- ACC_WIDTH, 40, signed accumulator width
- clk  input  1  clock
- rst  input  1  reset: synchronous, active-high
- start  input  1  request one layer evaluation; sampled only in IDLE
- data_in  input  NN_DATA_WIDTH x NN_ARRAY_WIDTH  unpacked feature array, signed
- w_en  output  1  weight memory read enable
- w_addr  output  $clog2(N*(A+1))  weight memory address
- w_data  input  NN_DATA_WIDTH  weight/bias read data; valid 1 cycle after w_en
- busy  output  1  evaluation in progress
- out_valid  output  1  single-cycle strobe: out_data/out_index are valid
- out_data  output  NN_DATA_WIDTH  neuron result, signed
- out_index  output  $clog2(N)  neuron number of out_data
- done  output  1  single-cycle pulse after the last neuron is emitted

## Operation
- Memory map: neuron n occupies addresses n*(A+1)+k. Slots k=0..A-1 hold weights; slot k=A holds the bias.
- States: IDLE, MAC, DRAIN, OUT.
- IDLE: when start=1, snapshot data_in into internal registers, clear the accumulator, set n=0 and k=0, then go to MAC. Later changes on data_in have no effect until the next start.
- MAC: drive w_en=1 and w_addr=n*(A+1)+k. Increment k each cycle. After issuing k=A, go to DRAIN.
- Accumulation lags addressing by one cycle.
  - For k<A: acc += sext(snapshot[k]*w_data). The product is a 2*NN_DATA_WIDTH-bit signed value.
  - For k=A: acc += sext(w_data) <<< FRAC_BITS.
- DRAIN: w_en=0. The bias accumulation completes in this cycle. Go to OUT.
- OUT: register the result:
  - r = acc >>> FRAC_BITS (arithmetic shift).
  - Saturate r to [-2^(DW-1), 2^(DW-1)-1].
  - Apply ReLU if enabled.
  - Assert out_valid=1 with out_index=n.
- From OUT:
  - If n<N-1: set n++, k=0, clear acc, go to MAC.
  - Otherwise: pulse done, drop busy, go to IDLE.
- start is ignored while busy=1.
- rst at any time:
  - state returns to IDLE and the accumulator is cleared.
  - No done or out_valid is generated for the aborted run.
- Reset values: busy=0, done=0, out_valid=0, out_data=0, out_index=0, w_en=0, w_addr=0.
- The accumulator does not wrap for full-scale operands with the default widths. ACC_WIDTH must be at least 2*DW+$clog2(A+1)+1.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE.
- busy is high from cycle 1 through cycle N*(A+3), inclusive.
- For neuron n, let base = n*(A+3). Then:
  - Addresses are issued in cycles base+1 .. base+A+1.
  - DRAIN occurs in cycle base+A+2.
  - out_valid occurs in cycle (n+1)*(A+3).
- With the defaults, out_valid is at cycles 29, 58, …, 232.
- done=1 in cycle N*(A+3)+1 (233 with defaults), with busy=0 in the same cycle.
- The earliest accepted new start is in cycle N*(A+3)+1.
- out_data and out_index hold their value after out_valid falls until the next OUT.

## Configuration
- NN_RELU_EN defined: negative saturated results are output as 0.
- NN_RELU_EN undefined: the signed saturated result is output unchanged (linear layer).

## Test plan
- Timing check:
  - Stimulus: all weights 0, every bias = 5, one start pulse.
  - Required: out_valid at cycles 29, 58, …, 232; out_data=5 and out_index=0..7 in order; done at 233; busy high in cycles 1–232.
- Unit weight:
  - Stimulus: data_in all 0x0100 (1.0); neuron 0 has weight k=0 equal to 0x0100, all other weights and bias 0.
  - Required: neuron 0 outputs 0x0100; all other neurons output 0.
- Saturation:
  - Stimulus: data_in all 0x7FFF; all weights 0x7FFF.
  - Required: every output is 0x7FFF.
- Sign and ReLU:
  - Stimulus: data_in[0]=0x0100; weight 0xFF00 (−1.0).
  - Required: output 0x0000 with NN_RELU_EN defined; 0xFF00 without it.
- Start during busy:
  - Stimulus: start asserted at cycle 10 of a run.
  - Required: ignored, so exactly 8 out_valid strobes and 1 done.
  - Stimulus: data_in changed at cycle 5.
  - Required: results unchanged because the snapshot is used.
- Reset mid-run:
  - Stimulus: rst at cycle 40, then a fresh start.
  - Required: all outputs at their reset values, no done; the fresh run produces correct results with the standard timing.

Source files
------------

// File: rtl/nn_dense_layer_if.sv
// nn_dense_layer_if: start/feature, weight-memory and result bundle of the dense layer.
// The layer itself uses the slave modport; the feature source / memory / consumer side uses master.
interface nn_dense_layer_if #(
  parameter int unsigned NN_DATA_WIDTH  = 16,
  parameter int unsigned NN_ARRAY_WIDTH = 26,
  parameter int unsigned NUM_NEURONS    = 8
);
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_NEURONS * (NN_ARRAY_WIDTH + 1));
  localparam int unsigned IDX_WIDTH  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;

  logic                            start;
  logic signed [NN_DATA_WIDTH-1:0] data_in [NN_ARRAY_WIDTH];
  logic                            w_en;
  logic        [ADDR_WIDTH-1:0]    w_addr;
  logic signed [NN_DATA_WIDTH-1:0] w_data;
  logic                            busy;
  logic                            out_valid;
  logic signed [NN_DATA_WIDTH-1:0] out_data;
  logic        [IDX_WIDTH-1:0]     out_index;
  logic                            done;

  modport master (
    output start, data_in, w_data,
    input  w_en, w_addr, busy, out_valid, out_data, out_index, done
  );

  modport slave (
    input  start, data_in, w_data,
    output w_en, w_addr, busy, out_valid, out_data, out_index, done
  );
endinterface

// File: rtl/nn_dense_layer.sv
// nn_dense_layer: serial multiply-accumulate fully connected layer over a synchronous weight memory.
// Optional macro NN_RELU_EN clamps negative neuron results to zero; undefined gives a linear layer.
module nn_dense_layer #(
  parameter int unsigned NN_DATA_WIDTH  = 16,
  parameter int unsigned NN_ARRAY_WIDTH = 26,
  parameter int unsigned NUM_NEURONS    = 8,
  parameter int unsigned FRAC_BITS      = 8,
  parameter int unsigned ACC_WIDTH      = 40
) (
  input  logic            clk,
  input  logic            rst,
  nn_dense_layer_if.slave bus
);
  localparam int unsigned DW     = NN_DATA_WIDTH;
  localparam int unsigned A      = NN_ARRAY_WIDTH;
  localparam int unsigned N      = NUM_NEURONS;
  localparam int unsigned STRIDE = A + 1;
  localparam int unsigned AW     = $clog2(N * STRIDE);
  localparam int unsigned IW     = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned KW     = $clog2(STRIDE);
  localparam int unsigned PW     = 2 * DW;

  localparam logic [KW-1:0] K_BIAS = KW'(A);
  localparam logic [IW-1:0] N_LAST = IW'(N - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic signed [DW-1:0]        snap_q [A];
  logic signed [DW-1:0]        snap_d [A];
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]               n_q, n_d;
  logic [KW-1:0]               k_q, k_d;
  logic                        rd_vld_q, rd_vld_d;
  logic [KW-1:0]               rd_k_q, rd_k_d;

  logic                        w_en_q, w_en_d;
  logic [AW-1:0]               w_addr_q, w_addr_d;
  logic                        busy_q, busy_d;
  logic                        out_valid_q, out_valid_d;
  logic signed [DW-1:0]        out_data_q, out_data_d;
  logic [IW-1:0]               out_index_q, out_index_d;
  logic                        done_q, done_d;

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] res;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_MAC;
      S_MAC:   if (k_q == K_BIAS) state_d = S_DRAIN;
      S_DRAIN: state_d = S_OUT;
      S_OUT:   state_d = (n_q == N_LAST) ? S_IDLE : S_MAC;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    snap_d      = snap_q;
    acc_d       = acc_q;
    n_d         = n_q;
    k_d         = k_q;
    rd_vld_d    = w_en_q;
    rd_k_d      = k_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    done_d      = 1'b0;
    prod        = '0;
    res         = '0;

    // Memory data lags the address by a cycle, so accumulate the slot issued last cycle
    if (rd_vld_q) begin
      if (rd_k_q == K_BIAS) begin
        acc_d = acc_q + (ACC_WIDTH'(bus.w_data) <<< FRAC_BITS);
      end else begin
        prod  = PW'(snap_q[rd_k_q]) * PW'(bus.w_data);
        acc_d = acc_q + ACC_WIDTH'(prod);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          snap_d = bus.data_in;
          acc_d  = '0;
          n_d    = '0;
          k_d    = '0;
        end
      end
      S_MAC: begin
        if (k_q != K_BIAS) k_d = k_q + KW'(1);
      end
      S_DRAIN: begin
        // acc_d already holds the bias term here; rescale, saturate, then register for OUT
        res = acc_d >>> FRAC_BITS;
        if (res > SAT_MAX)      res = SAT_MAX;
        else if (res < SAT_MIN) res = SAT_MIN;
        out_data_d = DW'(res);
`ifdef NN_RELU_EN
        if (out_data_d[DW-1]) out_data_d = '0;
`endif
        out_valid_d = 1'b1;
        out_index_d = n_q;
      end
      S_OUT: begin
        if (n_q != N_LAST) begin
          n_d   = n_q + IW'(1);
          k_d   = '0;
          acc_d = '0;
        end else begin
          done_d = 1'b1;
        end
      end
      default: ;
    endcase

    w_en_d   = (state_d == S_MAC);
    w_addr_d = w_en_d ? AW'(32'(n_d) * STRIDE + 32'(k_d)) : w_addr_q;
    busy_d   = (state_d != S_IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q      <= '{default: '0};
      acc_q       <= '0;
      n_q         <= '0;
      k_q         <= '0;
      rd_vld_q    <= 1'b0;
      rd_k_q      <= '0;
      w_en_q      <= 1'b0;
      w_addr_q    <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      done_q      <= 1'b0;
    end else begin
      snap_q      <= snap_d;
      acc_q       <= acc_d;
      n_q         <= n_d;
      k_q         <= k_d;
      rd_vld_q    <= rd_vld_d;
      rd_k_q      <= rd_k_d;
      w_en_q      <= w_en_d;
      w_addr_q    <= w_addr_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      done_q      <= done_d;
    end
  end

  assign bus.w_en      = w_en_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_index = out_index_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_nn_dense_layer.sv
// tb_nn_dense_layer: scenario tasks driving nn_dense_layer against a synchronous weight memory,
// with results compared to an integer-arithmetic reference of the layer equation.
module tb_nn_dense_layer;
  localparam int DW   = 16;
  localparam int A    = 26;
  localparam int N    = 8;
  localparam int F    = 8;
  localparam int ACCW = 40;
  localparam int LAT  = N * (A + 3);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nn_dense_layer_if #(.NN_DATA_WIDTH(DW), .NN_ARRAY_WIDTH(A), .NUM_NEURONS(N)) bus ();

  nn_dense_layer #(
    .NN_DATA_WIDTH(DW), .NN_ARRAY_WIDTH(A), .NUM_NEURONS(N), .FRAC_BITS(F), .ACC_WIDTH(ACCW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic signed [DW-1:0] mem [N*(A+1)];
  logic signed [DW-1:0] din [2][A];

  // Synchronous weight memory: read data one cycle after w_en
  always @(posedge clk) if (bus.w_en) bus.w_data <= mem[bus.w_addr];

  int vectors = 0;
  int miscompares = 0;

  int            ov_cyc[$];
  logic [DW-1:0] ov_data[$];
  int            ov_idx[$];
  int            done_cyc[$];
  int            busy_bad;

  // Reference: sum of products plus bias scaled to the product format, rescale, saturate, ReLU
  function automatic logic [DW-1:0] ref_out(input int n, input int s);
    longint acc = 0;
    longint r;
    for (int k = 0; k < A; k++) acc += longint'(din[s][k]) * longint'(mem[n*(A+1)+k]);
    acc += longint'(mem[n*(A+1)+A]) * (longint'(1) << F);
    r = acc >>> F;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`ifdef NN_RELU_EN
    if (r < 0) r = 0;
`endif
    return DW'(r);
  endfunction

  // Runs n_runs back-to-back evaluations and records what the DUT shows each cycle
  task automatic run_layer(input int n_runs, input bit perturb, input bit poke_start);
    int total = n_runs * (LAT + 1) + 3;
    ov_cyc.delete(); ov_data.delete(); ov_idx.delete(); done_cyc.delete();
    busy_bad = 0;
    @(negedge clk);
    bus.data_in = din[0];
    bus.start   = 1'b1;
    for (int c = 1; c <= total; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (perturb && c == 5) for (int k = 0; k < A; k++) bus.data_in[k] = DW'($urandom);
      if (poke_start && c == 10) bus.start = 1'b1;
      if (c % (LAT + 1) == 0 && c / (LAT + 1) < n_runs) begin
        bus.data_in = din[c / (LAT + 1)];
        bus.start   = 1'b1;
      end
      if (bus.out_valid) begin
        ov_cyc.push_back(c);
        ov_data.push_back(bus.out_data);
        ov_idx.push_back(int'(bus.out_index));
      end
      if (bus.done) done_cyc.push_back(c);
      if (bus.busy !== ((c % (LAT + 1) != 0) && (c < n_runs * (LAT + 1)))) busy_bad++;
    end
  endtask

  task automatic randomize_layer(input int sh);
    logic signed [DW-1:0] v;
    for (int i = 0; i < N*(A+1); i++) begin v = DW'($urandom); mem[i] = v >>> sh; end
    for (int s = 0; s < 2; s++)
      for (int k = 0; k < A; k++) begin v = DW'($urandom); din[s][k] = v >>> sh; end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({bus.busy, bus.done, bus.out_valid, bus.w_en, bus.out_data, bus.out_index, bus.w_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: busy=%b done=%b out_valid=%b w_en=%b out_data=%h out_index=%0d w_addr=%0d, want all 0",
               bus.busy, bus.done, bus.out_valid, bus.w_en, bus.out_data, bus.out_index, bus.w_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_timing;
    randomize_layer(0);
    for (int n = 0; n < N; n++) begin
      for (int k = 0; k < A; k++) mem[n*(A+1)+k] = '0;
      mem[n*(A+1)+A] = 16'sd5;
    end
    run_layer(1, 1'b0, 1'b0);
    vectors++;
    if (ov_cyc.size() != N) begin miscompares++; $display("FAIL timing_count: got %0d strobes, want %0d", ov_cyc.size(), N); end
    for (int i = 0; i < N; i++) begin
      int            c = (i < ov_cyc.size()) ? ov_cyc[i] : -1;
      int            x = (i < ov_idx.size()) ? ov_idx[i] : -1;
      logic [DW-1:0] d = (i < ov_data.size()) ? ov_data[i] : 'x;
      vectors += 3;
      if (c != (i + 1) * (A + 3)) begin miscompares++; $display("FAIL timing_cycle[%0d]: got %0d, want %0d", i, c, (i + 1) * (A + 3)); end
      if (x != i) begin miscompares++; $display("FAIL timing_index[%0d]: got %0d, want %0d", i, x, i); end
      if (d !== 16'h0005) begin miscompares++; $display("FAIL timing_data[%0d]: got %h, want 0005", i, d); end
    end
    vectors += 2;
    if (done_cyc.size() != 1 || done_cyc[0] != LAT + 1) begin
      miscompares++; $display("FAIL timing_done: got %0d pulses (first at %0d), want 1 at %0d",
                              done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1, LAT + 1);
    end
    if (busy_bad != 0) begin miscompares++; $display("FAIL timing_busy: got %0d bad cycles, want 0", busy_bad); end
  endtask

  task automatic test_unit_weight;
    for (int i = 0; i < N*(A+1); i++) mem[i] = '0;
    mem[0] = 16'sh0100;
    for (int k = 0; k < A; k++) din[0][k] = 16'sh0100;
    run_layer(1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      logic [DW-1:0] d = (i < ov_data.size()) ? ov_data[i] : 'x;
      logic [DW-1:0] e = (i == 0) ? 16'h0100 : 16'h0000;
      vectors++;
      if (d !== e) begin miscompares++; $display("FAIL unit_weight[%0d]: got %h, want %h", i, d, e); end
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < N*(A+1); i++) mem[i] = 16'sh7FFF;
    for (int k = 0; k < A; k++) din[0][k] = 16'sh7FFF;
    run_layer(1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      logic [DW-1:0] d = (i < ov_data.size()) ? ov_data[i] : 'x;
      vectors++;
      if (d !== 16'h7FFF) begin miscompares++; $display("FAIL saturation[%0d]: got %h, want 7fff", i, d); end
    end
  endtask

  task automatic test_sign_relu;
    logic [DW-1:0] e;
`ifdef NN_RELU_EN
    e = 16'h0000;
`else
    e = 16'hFF00;
`endif
    randomize_layer(0);
    for (int i = 0; i < N*(A+1); i++) mem[i] = '0;
    for (int n = 0; n < N; n++) mem[n*(A+1)] = 16'shFF00;
    din[0][0] = 16'sh0100;
    run_layer(1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      logic [DW-1:0] d = (i < ov_data.size()) ? ov_data[i] : 'x;
      vectors++;
      if (d !== e) begin miscompares++; $display("FAIL sign_relu[%0d]: got %h, want %h", i, d, e); end
    end
  endtask

  task automatic test_random;
    for (int round = 0; round < 3; round++) begin
      randomize_layer(4 + 2 * round);
      run_layer(1, 1'b0, 1'b0);
      vectors++;
      if (ov_data.size() != N) begin miscompares++; $display("FAIL random_count: got %0d, want %0d", ov_data.size(), N); end
      for (int i = 0; i < N; i++) begin
        logic [DW-1:0] d = (i < ov_data.size()) ? ov_data[i] : 'x;
        int            x = (i < ov_idx.size()) ? ov_idx[i] : -1;
        vectors += 2;
        if (d !== ref_out(i, 0)) begin miscompares++; $display("FAIL random_data r%0d[%0d]: got %h, want %h", round, i, d, ref_out(i, 0)); end
        if (x != i) begin miscompares++; $display("FAIL random_index r%0d[%0d]: got %0d, want %0d", round, i, x, i); end
      end
    end
  endtask

  task automatic test_start_during_busy;
    randomize_layer(5);
    run_layer(1, 1'b1, 1'b1);
    vectors += 2;
    if (ov_data.size() != N) begin miscompares++; $display("FAIL busy_start_strobes: got %0d, want %0d", ov_data.size(), N); end
    if (done_cyc.size() != 1) begin miscompares++; $display("FAIL busy_start_done: got %0d, want 1", done_cyc.size()); end
    for (int i = 0; i < N; i++) begin
      logic [DW-1:0] d = (i < ov_data.size()) ? ov_data[i] : 'x;
      vectors++;
      if (d !== ref_out(i, 0)) begin miscompares++; $display("FAIL snapshot_data[%0d]: got %h, want %h", i, d, ref_out(i, 0)); end
    end
  endtask

  task automatic test_back_to_back;
    randomize_layer(6);
    run_layer(2, 1'b0, 1'b0);
    vectors++;
    if (ov_data.size() != 2 * N) begin miscompares++; $display("FAIL b2b_count: got %0d, want %0d", ov_data.size(), 2 * N); end
    for (int i = 0; i < 2 * N; i++) begin
      int            r = i / N;
      int            n = i % N;
      int            c = (i < ov_cyc.size()) ? ov_cyc[i] : -1;
      logic [DW-1:0] d = (i < ov_data.size()) ? ov_data[i] : 'x;
      vectors += 2;
      if (c != r * (LAT + 1) + (n + 1) * (A + 3)) begin
        miscompares++; $display("FAIL b2b_cycle[%0d]: got %0d, want %0d", i, c, r * (LAT + 1) + (n + 1) * (A + 3));
      end
      if (d !== ref_out(n, r)) begin miscompares++; $display("FAIL b2b_data[%0d]: got %h, want %h", i, d, ref_out(n, r)); end
    end
    vectors += 2;
    if (done_cyc.size() != 2 || done_cyc[0] != LAT + 1 || done_cyc[1] != 2 * (LAT + 1)) begin
      miscompares++; $display("FAIL b2b_done: got %0d pulses, want 2 at %0d and %0d", done_cyc.size(), LAT + 1, 2 * (LAT + 1));
    end
    if (busy_bad != 0) begin miscompares++; $display("FAIL b2b_busy: got %0d bad cycles, want 0", busy_bad); end
  endtask

  task automatic test_reset_mid_run;
    int nv = 0;
    int nd = 0;
    randomize_layer(5);
    @(negedge clk);
    bus.data_in = din[0];
    bus.start   = 1'b1;
    for (int c = 1; c <= LAT + 5; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 40) rst = 1'b1;
      if (c == 41) begin
        rst = 1'b0;
        vectors++;
        if ({bus.busy, bus.done, bus.out_valid, bus.w_en, bus.out_data, bus.out_index, bus.w_addr} !== '0) begin
          miscompares++;
          $display("FAIL midrun_reset_values: busy=%b done=%b out_valid=%b w_en=%b out_data=%h out_index=%0d w_addr=%0d, want all 0",
                   bus.busy, bus.done, bus.out_valid, bus.w_en, bus.out_data, bus.out_index, bus.w_addr);
        end
      end
      if (c > 40 && bus.out_valid) nv++;
      if (c > 40 && bus.done) nd++;
    end
    vectors += 2;
    if (nv != 0) begin miscompares++; $display("FAIL midrun_out_valid: got %0d strobes after reset, want 0", nv); end
    if (nd != 0) begin miscompares++; $display("FAIL midrun_done: got %0d pulses after reset, want 0", nd); end
    randomize_layer(5);
    run_layer(1, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      int            c = (i < ov_cyc.size()) ? ov_cyc[i] : -1;
      logic [DW-1:0] d = (i < ov_data.size()) ? ov_data[i] : 'x;
      vectors += 2;
      if (c != (i + 1) * (A + 3)) begin miscompares++; $display("FAIL fresh_cycle[%0d]: got %0d, want %0d", i, c, (i + 1) * (A + 3)); end
      if (d !== ref_out(i, 0)) begin miscompares++; $display("FAIL fresh_data[%0d]: got %h, want %h", i, d, ref_out(i, 0)); end
    end
    vectors++;
    if (done_cyc.size() != 1 || done_cyc[0] != LAT + 1) begin
      miscompares++; $display("FAIL fresh_done: got %0d pulses, want 1 at %0d", done_cyc.size(), LAT + 1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    for (int k = 0; k < A; k++) bus.data_in[k] = '0;
    test_reset();
    test_timing();
    test_unit_weight();
    test_saturation();
    test_sign_relu();
    test_random();
    test_start_during_busy();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
